// File: rtl/axil_rr_master_arbiter.sv
// axil_rr_master_arbiter: round-robin sharing of one AXI4-Lite master port among NREQ single-beat requesters
module axil_rr_master_arbiter #(
  parameter int NREQ = 2,
  parameter int AW = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  input  logic [NREQ*4-1:0]  req_wstrb,
  output logic [NREQ-1:0]   req_ack,
  output logic [31:0]       req_rdata,
  output logic [1:0]        req_resp,
  output logic              busy,
  output logic [AW-1:0]     M_AXI_AWADDR,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [AW-1:0]     M_AXI_ARADDR,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);
  localparam int GW = (NREQ > 2) ? 2 : 1;
  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, ACK} state_t;
  state_t state, state_n;
  logic [GW-1:0] p, g, win, idx;
  logic any, aw_done, w_done, aw_ok, w_ok;
  logic [AW-1:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0] wstrb_q;
  logic [1:0] resp_q;
  assign aw_ok = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_ok = w_done | (M_AXI_WVALID & M_AXI_WREADY);
  // pick the first valid requester scanning p, p+1, ... (descending loop so the nearest one wins)
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = GW'((int'(p) + k) % NREQ);
      if (req_valid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else state <= state_n;
  end
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = any ? (req_we[win] ? WR : RA) : IDLE;
      WR:   state_n = (aw_ok && w_ok) ? WB : WR;
      WB:   state_n = M_AXI_BVALID ? ACK : WB;
      RA:   state_n = M_AXI_ARREADY ? RD : RA;
      RD:   state_n = M_AXI_RVALID ? ACK : RD;
      ACK:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // AXI and requester outputs decoded from state; payloads come from latched registers only
  always_comb begin
    M_AXI_AWVALID = state == WR && !aw_done;
    M_AXI_WVALID = state == WR && !w_done;
    M_AXI_BREADY = state == WB;
    M_AXI_ARVALID = state == RA;
    M_AXI_RREADY = state == RD;
    M_AXI_AWADDR = addr_q;
    M_AXI_ARADDR = addr_q;
    M_AXI_WDATA = wdata_q;
    M_AXI_WSTRB = wstrb_q;
    M_AXI_AWPROT = 3'b000;
    M_AXI_ARPROT = 3'b000;
    busy = state != IDLE;
    req_ack = (state == ACK) ? (NREQ'(1) << g) : '0;
    req_rdata = rdata_q;
    req_resp = resp_q;
  end
  // grant latch, pointer update, handshake tracking and response capture
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      p <= '0;
      g <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        g <= win;
        p <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        addr_q <= req_addr[int'(win)*AW +: AW];
        wdata_q <= req_wdata[int'(win)*32 +: 32];
        wstrb_q <= req_wstrb[int'(win)*4 +: 4];
      end
      aw_done <= state == WR && aw_ok;
      w_done <= state == WR && w_ok;
      if (state == WB && M_AXI_BVALID) resp_q <= M_AXI_BRESP;
      if (state == RD && M_AXI_RVALID) begin
        rdata_q <= M_AXI_RDATA;
        resp_q <= M_AXI_RRESP;
      end
    end
  end
endmodule

// File: tb/tb_axil_rr_master_arbiter.sv
// tb_axil_rr_master_arbiter: randomized scoreboard bench with an AXI4-Lite slave model
module tb_axil_rr_master_arbiter;
  localparam int NREQ = 2;
  localparam int AW = 32;
  logic tb_ACLK = 1'b0;
  logic ARESET;
  logic [NREQ-1:0] req_valid, req_we, req_ack;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ*4-1:0] req_wstrb;
  logic [31:0] req_rdata;
  logic [1:0] req_resp;
  logic busy;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0] AWPROT, ARPROT;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;

  always #5 tb_ACLK = ~tb_ACLK;

  axil_rr_master_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .ACLK(tb_ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ack(req_ack), .req_rdata(req_rdata), .req_resp(req_resp),
    .busy(busy),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  typedef struct packed {
    int who;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    int lat;
  } cmd_t;
  typedef struct packed {
    int who;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic [31:0] rdata;
    logic [1:0] resp;
    int cyc;
  } exp_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  int mp = 0;
  int c1_cyc = -10;
  bit want_c1 = 0;
  cmd_t pend[$];
  cmd_t dq[$];
  exp_t exq[$];
  logic [31:0] m_mem [logic [29:0]];
  logic [31:0] s_mem [logic [29:0]];
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;

  always @(posedge tb_ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return a[15:12] == 4'hE ? 2'b10 : a[15:12] == 4'hD ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // AXI4-Lite slave: READY after a configurable number of VALID cycles, B/R a configurable delay after the request
  int aw_wait, w_wait, ar_wait, bcnt, rcnt;
  bit have_aw, have_w, bpend, rpend, b_fire, r_fire;
  logic [31:0] s_awaddr, s_wdata, s_araddr, rd_q;
  logic [3:0] s_wstrb;
  logic [1:0] bresp_q, rresp_q;
  initial begin
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
    BRESP = 0; RRESP = 0; RDATA = 0;
    {aw_wait, w_wait, ar_wait, bcnt, rcnt} = '0;
    {have_aw, have_w, bpend, rpend, b_fire, r_fire} = '0;
    s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0; rd_q = 0; bresp_q = 0; rresp_q = 0;
    forever begin
      @(negedge tb_ACLK);
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        {aw_wait, w_wait, ar_wait} = '0;
        {have_aw, have_w, bpend, rpend, b_fire, r_fire} = '0;
        continue;
      end
      if (b_fire) BVALID = 0;
      if (r_fire) RVALID = 0;
      if (bpend) begin
        if (bcnt == 0) begin BVALID = 1; BRESP = bresp_q; bpend = 0; end
        else bcnt--;
      end
      if (rpend) begin
        if (rcnt == 0) begin RVALID = 1; RDATA = rd_q; RRESP = rresp_q; rpend = 0; end
        else rcnt--;
      end
      AWREADY = 0;
      if (AWVALID && !have_aw) begin
        if (aw_wait >= aw_dly) begin AWREADY = 1; have_aw = 1; s_awaddr = AWADDR; aw_wait = 0; end
        else aw_wait++;
      end
      WREADY = 0;
      if (WVALID && !have_w) begin
        if (w_wait >= w_dly) begin WREADY = 1; have_w = 1; s_wdata = WDATA; s_wstrb = WSTRB; w_wait = 0; end
        else w_wait++;
      end
      if (have_aw && have_w) begin
        s_mem[s_awaddr[31:2]] = merge(s_mem.exists(s_awaddr[31:2]) ? s_mem[s_awaddr[31:2]] : 32'h0, s_wdata, s_wstrb);
        bresp_q = resp_of(s_awaddr);
        bpend = 1; bcnt = b_dly; have_aw = 0; have_w = 0;
      end
      ARREADY = 0;
      if (ARVALID) begin
        if (ar_wait >= ar_dly) begin
          ARREADY = 1; s_araddr = ARADDR; ar_wait = 0;
          rd_q = s_mem.exists(ARADDR[31:2]) ? s_mem[ARADDR[31:2]] : 32'h0;
          rresp_q = resp_of(ARADDR); rpend = 1; rcnt = r_dly;
        end else ar_wait++;
      end
      b_fire = BVALID && BREADY;
      r_fire = RVALID && RREADY;
    end
  end

  // monitor: protocol checks every cycle, scoreboard pop on every ack
  int n_aw = 0, n_w = 0;
  bit prev_aw, prev_w, prev_ar;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
  exp_t e;
  initial begin
    prev_aw = 0; prev_w = 0; prev_ar = 0;
    prev_awaddr = 0; prev_wdata = 0; prev_araddr = 0;
    forever begin
      @(negedge tb_ACLK);
      #1;
      if (ARESET) begin
        n_aw = 0; n_w = 0; prev_aw = 0; prev_w = 0; prev_ar = 0;
        continue;
      end
      if (prev_aw) chk("awvalid_hold", {AWVALID, AWADDR}, {1'b1, prev_awaddr});
      if (prev_w) chk("wvalid_hold", {WVALID, WDATA}, {1'b1, prev_wdata});
      if (prev_ar) chk("arvalid_hold", {ARVALID, ARADDR}, {1'b1, prev_araddr});
      prev_aw = AWVALID && !AWREADY; prev_awaddr = AWADDR;
      prev_w = WVALID && !WREADY; prev_wdata = WDATA;
      prev_ar = ARVALID && !ARREADY; prev_araddr = ARADDR;
      if (AWVALID && AWREADY) n_aw++;
      if (WVALID && WREADY) n_w++;
      if (BREADY) chk("bready_after_aw_w", {n_aw, n_w}, {32'd1, 32'd1});
      if (cyc == c1_cyc) begin
        chk("c1_awvalid_wvalid", {AWVALID, WVALID}, 2'b11);
        chk("c1_awaddr", AWADDR, 32'h4120_0000);
        chk("c1_wdata_wstrb", {WDATA, WSTRB}, {32'hFFFF_FFFF, 4'hF});
      end
      if (req_ack != 0) begin
        if (exq.size() == 0) chk("unexpected_ack", req_ack, 0);
        else begin
          e = exq.pop_front();
          chk("ack_onehot", req_ack, NREQ'(1) << e.who);
          chk("resp", req_resp, e.resp);
          if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
          if (e.we) begin
            chk("slave_awaddr", s_awaddr, e.addr);
            chk("slave_wdata_wstrb", {s_wdata, s_wstrb}, {e.wdata, e.wstrb});
            chk("one_aw_one_w", {n_aw, n_w}, {32'd1, 32'd1});
          end else begin
            chk("rdata", req_rdata, e.rdata);
            chk("slave_araddr", s_araddr, e.addr);
          end
        end
        n_aw = 0; n_w = 0;
      end
    end
  end

  task automatic add(input int who, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int lat);
    cmd_t c;
    c.who = who; c.we = we; c.addr = a; c.wdata = d; c.wstrb = s; c.lat = lat;
    pend.push_back(c);
  endtask

  task automatic add_rnd(input int who);
    int r;
    logic [31:0] a;
    r = $urandom_range(7);
    a = 32'h4000_0000 | (32'($urandom_range(7)) << 2);
    a[15:12] = r == 5 ? 4'h1 : r == 6 ? 4'hD : r == 7 ? 4'hE : 4'h0;
    add(who, 1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)), -1);
  endtask

  task automatic load_next(input int i);
    req_valid[i] = 0;
    for (int m = 0; m < dq.size(); m++)
      if (dq[m].who == i) begin
        req_valid[i] = 1;
        req_we[i] = dq[m].we;
        req_addr[i*AW +: AW] = dq[m].addr;
        req_wdata[i*32 +: 32] = dq[m].wdata;
        req_wstrb[i*4 +: 4] = dq[m].wstrb;
        dq.delete(m);
        break;
      end
  endtask

  // model: every requester with commands left is valid at each grant, so grants follow a plain rotation
  task automatic run_round();
    cmd_t q[$];
    exp_t x;
    int p, c0, t;
    bit found;
    @(posedge tb_ACLK);
    #1;
    c0 = cyc;
    if (want_c1) begin c1_cyc = c0 + 1; want_c1 = 0; end
    q = pend;
    p = mp;
    while (q.size() > 0) begin
      found = 0;
      for (int k = 0; k < NREQ && !found; k++)
        for (int m = 0; m < q.size(); m++)
          if (q[m].who == (p + k) % NREQ) begin
            x.who = q[m].who; x.we = q[m].we; x.addr = q[m].addr; x.wdata = q[m].wdata;
            x.wstrb = q[m].wstrb; x.resp = resp_of(q[m].addr);
            x.cyc = q[m].lat >= 0 ? c0 + q[m].lat : -1;
            x.rdata = m_mem.exists(x.addr[31:2]) ? m_mem[x.addr[31:2]] : 32'h0;
            if (x.we) m_mem[x.addr[31:2]] = merge(x.rdata, x.wdata, x.wstrb);
            exq.push_back(x);
            p = (x.who + 1) % NREQ;
            q.delete(m);
            found = 1;
            break;
          end
    end
    mp = p;
    dq = pend;
    pend.delete();
    for (int i = 0; i < NREQ; i++) load_next(i);
    t = 0;
    while (req_valid != 0 && t < 500) begin
      @(posedge tb_ACLK);
      #1;
      t++;
      for (int i = 0; i < NREQ; i++) if (req_ack[i]) load_next(i);
    end
    if (req_valid != 0) begin
      chk("round_timeout", req_valid, 0);
      req_valid = 0;
      exq.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    ARESET = 1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    #1;
    chk("reset_valid_ready", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    chk("reset_addr", {AWADDR, ARADDR}, 0);
    chk("reset_wdata_wstrb", {WDATA, WSTRB}, 0);
    chk("reset_req_outputs", {req_ack, req_rdata, req_resp, busy}, 0);
    chk("prot_tied", {AWPROT, ARPROT}, 0);
    @(posedge tb_ACLK);
    #1;
    ARESET = 0;
    want_c1 = 1;
    add(0, 1, 32'h4120_0000, 32'hFFFF_FFFF, 4'hF, 3);
    run_round();
    add(1, 1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF, -1);
    add(1, 0, 32'h4000_0000, 0, 0, -1);
    run_round();
    for (int n = 0; n < 2; n++) begin add_rnd(0); add_rnd(1); end
    run_round();
    aw_dly = 2;
    add(0, 1, 32'h4000_0004, 32'h1234_5678, 4'hF, 5);
    run_round();
    aw_dly = 0; w_dly = 2;
    add(0, 1, 32'h4000_0008, 32'h8765_4321, 4'h5, 5);
    run_round();
    w_dly = 0; ar_dly = 3; r_dly = 2;
    add(0, 0, 32'h4000_E010, 0, 0, 8);
    run_round();
    ar_dly = 0; r_dly = 0; b_dly = 6;
    @(posedge tb_ACLK);
    #1;
    req_valid = 2'b01; req_we = 2'b01;
    req_addr[0 +: AW] = 32'h4000_1008; req_wdata[0 +: 32] = 32'hCAFE_F00D; req_wstrb[0 +: 4] = 4'hF;
    m_mem[30'h1000_0402] = merge(m_mem.exists(30'h1000_0402) ? m_mem[30'h1000_0402] : 32'h0, 32'hCAFE_F00D, 4'hF);
    repeat (2) begin @(posedge tb_ACLK); #1; end
    chk("mid_write_in_wb", {BREADY, busy}, 2'b11);
    ARESET = 1;
    req_valid = 0;
    @(posedge tb_ACLK);
    #1;
    chk("rst_mid_valid_ready", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    chk("rst_mid_busy_ack", {busy, req_ack}, 0);
    @(posedge tb_ACLK);
    #1;
    exq.delete();
    mp = 0; b_dly = 0;
    ARESET = 0;
    add(1, 0, 32'h4000_1008, 0, 0, 3);
    run_round();
    for (int n = 0; n < 40; n++) begin
      aw_dly = $urandom_range(2); w_dly = $urandom_range(2); ar_dly = $urandom_range(3);
      b_dly = $urandom_range(2); r_dly = $urandom_range(2);
      for (int i = 0; i < NREQ; i++) repeat ($urandom_range(2)) add_rnd(i);
      if (pend.size() == 0) add_rnd(int'($urandom_range(NREQ - 1)));
      run_round();
    end
    repeat (6) @(posedge tb_ACLK);
    #1;
    chk("scoreboard_drained", exq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
